regfile_sdr_nrmw: RTL
=====================

# regfile_sdr_nrmw

Clocked, parametrised multi-port register file: the single-clock successor to the toysram 2R1W behavioural macro. It generalises to arbitrary width, depth and read/write port counts, registers read data, resolves same-address write conflicts by port priority, and self-clears its array after reset. It sits behind the core's operand-fetch and writeback stages as a drop-in array model for GPR/SPR files.

## Interface
- `WIDTH`, default 24: bits per entry.
- `DEPTH`, default 64: entries. Must be a power of two, ≥ 2.
- `NRD`, default 2: read ports, ≥ 1.
- `NWR`, default 1: write ports, ≥ 1.
- `AW`, default $clog2(DEPTH): address width. Derived; never overridden.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_done`  out  1  high once the post-reset array clear has finished.
- `rd_en`  in  NRD  per-port read strobe.
- `rd_addr`  in  NRD*AW  port p occupies slice [p*AW +: AW].
- `rd_dat`  out  NRD*WIDTH  registered read data; port p occupies slice [p*WIDTH +: WIDTH].
- `wr_en`  in  NWR  per-port write strobe.
- `wr_addr`  in  NWR*AW  packed as for `rd_addr`.
- `wr_dat`  in  NWR*WIDTH  packed as for `rd_dat`.
- `wr_collision`  out  1  registered one-cycle pulse: two or more enabled write ports targeted the same address in the previous cycle.

## Operation
- **Reset (rst_n low).**
  - `init_done` = 0, `rd_dat` = 0, `wr_collision` = 0, init counter = 0.
  - Array contents are not reset asynchronously.
- **INIT state** (entered on reset).
  - Each cycle writes 0 to entry `cnt`, then increments `cnt`.
  - After the cycle that writes entry DEPTH-1, moves to RUN and sets `init_done` = 1.
  - While in INIT, `wr_en` and `rd_en` are ignored, `rd_dat` holds 0, and `wr_collision` stays 0.
- **RUN state.** Terminal; left only via `rst_n`.
- **Write.**
  - On each edge where `wr_en[w]` = 1, `wr_dat[w]` is stored at `wr_addr[w]`.
  - If several enabled ports share an address, the highest-index port wins and `wr_collision` pulses the next cycle.
  - Writes to different addresses in the same cycle all commit.
- **Read.**
  - When `rd_en[p]` = 1, `rd_dat[p]` is loaded at the edge with the array entry at `rd_addr[p]`.
  - When `rd_en[p]` = 0, `rd_dat[p]` holds its previous value.
  - Read ports are fully independent; any number of them may read the same address.
- **Out of range.** Not possible, since DEPTH is a power of two.

## Timing
- Read latency is 1 cycle: address presented in cycle t, data valid after edge t, during cycle t+1.
- Write latency: data is committed at the edge ending cycle t.
  - A read of the same address in cycle t+1 returns the new value.
  - Same-cycle read/write interaction is governed by the Configuration macro below.
- Init duration: `init_done` rises exactly DEPTH rising edges after `rst_n` deasserts (the first edge with rst_n high writes entry 0).
- `wr_collision` asserts in cycle t+1 for a conflict in cycle t, and lasts 1 cycle per conflicting cycle.
- Reset asserted mid-INIT or mid-RUN:
  - All outputs clear immediately.
  - The init counter restarts at 0 and the full clear is repeated.
  - Any write in flight at the reset edge is lost.

## Configuration
- Macro: `REGFILE_SDR_NRMW_BYPASS_EN`.
- **Defined:** write-through bypass. A read in cycle t of an address written in cycle t returns the winning `wr_dat` for that address in cycle t+1.
- **Undefined:** read-before-write. The same read returns the pre-write array contents.
- INIT behaviour is identical in both builds.

## Structure
- Shared package `regfile_pkg` holds:
  - the `rf_state_t` enum (INIT, RUN);
  - default parameter constants (`RF_WIDTH_DEF` = 24, `RF_DEPTH_DEF` = 64);
  - a write-priority resolve function returning the winning port index and a hit flag for a given address.
- One sub-module, `regfile_init_seq`, contains the INIT/RUN FSM and the clear counter. It outputs `init_done`, `init_we` and `init_addr`.
- The top level contains the array, read registers, write-priority/collision logic and the optional bypass mux.

## Test plan
- **Reset and init:** release `rst_n`, DEPTH=64 → `init_done` low for 64 edges, high at edge 64. Reading all 64 addresses then returns 0. A `wr_en` pulse issued during INIT leaves its target address reading 0.
- **Basic write/read:** write 24'hA5A5A5 to address 17 on port 0. On the next cycle read address 17 on both read ports → both return 24'hA5A5A5 one cycle after `rd_en`. With `rd_en` low afterwards, `rd_dat` holds that value.
- **Write conflict:** NWR=2, both ports write address 5 (24'h111111 on port 0, 24'h222222 on port 1) → address 5 reads 24'h222222; `wr_collision` = 1 for exactly one cycle. Writing distinct addresses 5 and 6 → both commit, no collision pulse.
- **Same-cycle read/write:** address 9 holds 24'h000001. Write 24'h0000FF to address 9 and read address 9 in the same cycle → `rd_dat` = 24'h0000FF with the macro defined, 24'h000001 without it.
- **Reset mid-operation:** assert `rst_n` low asynchronously between edges while in RUN → `rd_dat` and `init_done` go to 0 immediately. After release, a full 64-cycle clear runs and previously written addresses read 0.
- **Parameter sweep:** WIDTH=8, DEPTH=4, NRD=3, NWR=2 and WIDTH=64, DEPTH=128, NRD=1, NWR=1 → random traffic matches a scoreboard model, and init takes DEPTH cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sdr_nrmw register file.
// The write-priority resolver is shared by the collision detector and the read bypass.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  localparam int RF_WIDTH_DEF = 24;
  localparam int RF_DEPTH_DEF = 64;
  localparam int RF_MAX_NWR   = 16;

  typedef logic [3:0] rf_idx_t;

  typedef struct packed {
    logic    hit;
    rf_idx_t idx;
  } wr_res_t;

  // match[w] = port w is enabled and targets the address of interest;
  // the highest-index matching port wins.
  function automatic wr_res_t wr_resolve(input logic [RF_MAX_NWR-1:0] match);
    wr_res_t r;
    r = '0;
    for (int w = 0; w < RF_MAX_NWR; w++) begin
      if (match[w]) begin
        r.hit = 1'b1;
        r.idx = rf_idx_t'(w);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sdr_nrmw_if.sv
// Bus bundle for regfile_sdr_nrmw: packed multi-port read/write signals plus status.
interface regfile_sdr_nrmw_if #(
  parameter int WIDTH = regfile_pkg::RF_WIDTH_DEF,
  parameter int DEPTH = regfile_pkg::RF_DEPTH_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(DEPTH)
);
  logic                 init_done;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_dat;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*WIDTH-1:0] wr_dat;
  logic                 wr_collision;

  modport master (
    input  init_done, rd_dat, wr_collision,
    output rd_en, rd_addr, wr_en, wr_addr, wr_dat
  );

  modport slave (
    output init_done, rd_dat, wr_collision,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_dat
  );
endinterface

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks every entry once, then parks in RUN.
//   state | meaning
//   INIT  | clearing entry cnt this cycle; user traffic ignored
//   RUN   | array usable; left only via rst_n
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_done,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);

  rf_state_t     state, state_nxt;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == AW'(DEPTH - 1)) state_nxt = RUN;
  end

  always_comb begin
    init_done = (state == RUN);
    init_we   = (state == INIT);
    init_addr = cnt;
  end

endmodule

// File: rtl/regfile_sdr_nrmw.sv
// Parametrised NRD-read / NWR-write register file with registered reads and self-clear.
// Optional macro REGFILE_SDR_NRMW_BYPASS_EN: same-cycle write-through to the read ports.
module regfile_sdr_nrmw
  import regfile_pkg::*;
#(
  parameter  int WIDTH = RF_WIDTH_DEF,
  parameter  int DEPTH = RF_DEPTH_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_sdr_nrmw_if.slave bus
);

  logic             run;
  logic             init_we;
  logic [AW-1:0]    init_addr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_next [NRD];
  logic [NRD*WIDTH-1:0] rd_q;
  logic [NWR-1:0]   wr_lose;
  logic             coll_q;

  regfile_init_seq #(.DEPTH(DEPTH)) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (run),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Later ports overwrite earlier ones in the loop, giving highest-index priority.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.wr_en[w]) mem[bus.wr_addr[w*AW +: AW]] <= bus.wr_dat[w*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    logic [RF_MAX_NWR-1:0] match;
    wr_res_t               res;

    always_comb begin
      match = '0;
      for (int v = 0; v < NWR; v++)
        match[v] = bus.wr_en[v] && (bus.wr_addr[v*AW +: AW] == bus.wr_addr[w*AW +: AW]);
    end

    assign res        = wr_resolve(match);
    assign wr_lose[w] = bus.wr_en[w] && res.hit && (res.idx != rf_idx_t'(w));
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = bus.rd_addr[p*AW +: AW];
`ifdef REGFILE_SDR_NRMW_BYPASS_EN
    logic [RF_MAX_NWR-1:0] match;
    wr_res_t               res;

    always_comb begin
      match = '0;
      for (int v = 0; v < NWR; v++)
        match[v] = bus.wr_en[v] && (bus.wr_addr[v*AW +: AW] == ra);
    end

    assign res        = wr_resolve(match);
    assign rd_next[p] = res.hit ? bus.wr_dat[int'(res.idx)*WIDTH +: WIDTH] : mem[ra];
`else
    assign rd_next[p] = mem[ra];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (run) begin
      for (int p = 0; p < NRD; p++) begin
        if (bus.rd_en[p]) rd_q[p*WIDTH +: WIDTH] <= rd_next[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll_q <= 1'b0;
    else        coll_q <= run && (|wr_lose);
  end

  assign bus.init_done    = run;
  assign bus.rd_dat       = rd_q;
  assign bus.wr_collision = coll_q;

endmodule
